// File: rtl/cart_save_ctrl.sv
// Cartridge backup RAM controller: shares the RAM port between CPU and host
// block device, loading/saving the 8 KiB image in 512-byte blocks.
module cart_save_ctrl #(
  parameter int RAM_AW = 13,
  parameter int BLK_AW = 9,
  parameter int NBLK   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_resb,
  input  logic [RAM_AW-1:0]        i_cpu_a,
  input  logic [7:0]               i_cpu_di,
  output logic [7:0]               o_cpu_do,
  input  logic                     i_cpu_csb,
  input  logic                     i_cpu_wrb,
  output logic                     o_hold,
  output logic [RAM_AW-1:0]        o_ram_a,
  output logic [7:0]               o_ram_di,
  input  logic [7:0]               i_ram_do,
  output logic                     o_ram_csb,
  output logic                     o_ram_wrb,
  input  logic                     i_img_mounted,
  input  logic [31:0]              i_img_size,
  input  logic                     i_save_req,
  output logic [RAM_AW-BLK_AW-1:0] o_sd_lba,
  output logic                     o_sd_rd,
  output logic                     o_sd_wr,
  input  logic                     i_sd_ack,
  input  logic [BLK_AW-1:0]        i_sd_buff_addr,
  input  logic [7:0]               i_sd_buff_dout,
  input  logic                     i_sd_buff_wr,
  output logic [7:0]               o_sd_buff_din,
  output logic                     o_dirty,
  output logic                     o_busy
);

  localparam int LBA_W = RAM_AW - BLK_AW;
  localparam logic [31:0] IMG_BYTES = 32'(2 ** RAM_AW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_REQ,
    S_XFER,
    S_NEXT
  } state_t;

  state_t           r_state;
  logic             r_hold;
  logic             r_busy;
  logic             r_dirty;
  logic             r_mounted;
  logic             r_pendLoad;
  logic             r_pendSave;
  logic             r_dirSave;
  logic [LBA_W-1:0] r_lba;
  logic             r_sdRd;
  logic             r_sdWr;

  logic w_cpuWrite;
  logic w_lastBlk;

  assign w_cpuWrite = !r_hold && !i_cpu_csb && !i_cpu_wrb;
  assign w_lastBlk  = (r_lba == LBA_W'(NBLK - 1));

  // Later assignments win: a finishing transfer clears its own pending flag
  // even if a new request for it arrives in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_resb) begin
      r_state    <= S_IDLE;
      r_hold     <= 1'b0;
      r_busy     <= 1'b0;
      r_dirty    <= 1'b0;
      r_mounted  <= 1'b0;
      r_pendLoad <= 1'b0;
      r_pendSave <= 1'b0;
      r_dirSave  <= 1'b0;
      r_lba      <= '0;
      r_sdRd     <= 1'b0;
      r_sdWr     <= 1'b0;
    end else begin
      if (w_cpuWrite)
        r_dirty <= 1'b1;

      if (i_img_mounted && !r_busy) begin
        r_mounted <= 1'b1;
        if (i_img_size == IMG_BYTES)
          r_pendLoad <= 1'b1;
      end

      if (i_save_req && r_mounted && r_dirty)
        r_pendSave <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pendLoad || r_pendSave) begin
            r_dirSave <= !r_pendLoad;
            r_lba     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (i_cpu_csb) begin
            r_hold  <= 1'b1;
            r_sdRd  <= !r_dirSave;
            r_sdWr  <= r_dirSave;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_sd_ack) begin
            r_sdRd  <= 1'b0;
            r_sdWr  <= 1'b0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (!i_sd_ack)
            r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_lastBlk) begin
            if (r_dirSave)
              r_pendSave <= 1'b0;
            else
              r_pendLoad <= 1'b0;
            r_dirty <= 1'b0;
            r_hold  <= 1'b0;
            // Stay busy when the other direction is queued so it follows directly.
            r_busy  <= r_dirSave ? r_pendLoad : r_pendSave;
            r_lba   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_lba   <= r_lba + LBA_W'(1);
            r_sdRd  <= !r_dirSave;
            r_sdWr  <= r_dirSave;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // While held, the RAM is only selected for host byte accesses in XFER.
  always_comb begin
    o_ram_a   = i_cpu_a;
    o_ram_di  = i_cpu_di;
    o_ram_csb = i_cpu_csb;
    o_ram_wrb = i_cpu_wrb;
    if (r_hold) begin
      o_ram_a   = {r_lba, i_sd_buff_addr};
      o_ram_di  = i_sd_buff_dout;
      o_ram_csb = 1'b1;
      o_ram_wrb = 1'b1;
      if (r_state == S_XFER) begin
        if (r_dirSave) begin
          o_ram_csb = 1'b0;
        end else if (i_sd_buff_wr) begin
          o_ram_csb = 1'b0;
          o_ram_wrb = 1'b0;
        end
      end
    end
  end

  assign o_cpu_do      = i_ram_do;
  assign o_sd_buff_din = i_ram_do;
  assign o_hold        = r_hold;
  assign o_busy        = r_busy;
  assign o_dirty       = r_dirty;
  assign o_sd_lba      = r_lba;
  assign o_sd_rd       = r_sdRd;
  assign o_sd_wr       = r_sdWr;

endmodule

// File: tb/tb_cart_save_ctrl.sv
// Bench for cart_save_ctrl: RAM model, host block-device responder that doubles
// as the scoreboard monitor, and directed CPU/mount/save scenarios.
module tb_cart_save_ctrl;

  localparam int RAM_BYTES = 8192;
  localparam int BLK_BYTES = 512;

  typedef struct packed {
    logic       dir;
    logic [3:0] lba;
  } req_t;

  logic        clk = 1'b0;
  logic        resb = 1'b0;
  logic [12:0] cpuA = '0;
  logic [7:0]  cpuDi = '0;
  logic [7:0]  cpuDo;
  logic        cpuCsb = 1'b1;
  logic        cpuWrb = 1'b1;
  logic        hold;
  logic [12:0] ramA;
  logic [7:0]  ramDi;
  logic [7:0]  ramDo = '0;
  logic        ramCsb;
  logic        ramWrb;
  logic        imgMounted = 1'b0;
  logic [31:0] imgSize = '0;
  logic        saveReq = 1'b0;
  logic [3:0]  sdLba;
  logic        sdRd;
  logic        sdWr;
  logic        sdAck = 1'b0;
  logic [8:0]  sdBuffAddr = '0;
  logic [7:0]  sdBuffDout = '0;
  logic        sdBuffWr = 1'b0;
  logic [7:0]  sdBuffDin;
  logic        dirty;
  logic        busy;

  logic [7:0] ramMem [RAM_BYTES] = '{default: 8'h00};
  logic [7:0] model  [RAM_BYTES] = '{default: 8'h00};

  req_t       expReq [$];
  logic [7:0] expData [$];
  int         checks = 0;
  int         errors = 0;
  int         reqSeen = 0;
  logic       hostXfer = 1'b0;

  always #5 clk = ~clk;

  cart_save_ctrl dut (
    .i_clk          (clk),
    .i_resb         (resb),
    .i_cpu_a        (cpuA),
    .i_cpu_di       (cpuDi),
    .o_cpu_do       (cpuDo),
    .i_cpu_csb      (cpuCsb),
    .i_cpu_wrb      (cpuWrb),
    .o_hold         (hold),
    .o_ram_a        (ramA),
    .o_ram_di       (ramDi),
    .i_ram_do       (ramDo),
    .o_ram_csb      (ramCsb),
    .o_ram_wrb      (ramWrb),
    .i_img_mounted  (imgMounted),
    .i_img_size     (imgSize),
    .i_save_req     (saveReq),
    .o_sd_lba       (sdLba),
    .o_sd_rd        (sdRd),
    .o_sd_wr        (sdWr),
    .i_sd_ack       (sdAck),
    .i_sd_buff_addr (sdBuffAddr),
    .i_sd_buff_dout (sdBuffDout),
    .i_sd_buff_wr   (sdBuffWr),
    .o_sd_buff_din  (sdBuffDin),
    .o_dirty        (dirty),
    .o_busy         (busy)
  );

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (!ramCsb) begin
      if (!ramWrb)
        ramMem[ramA] <= ramDi;
      ramDo <= ramMem[ramA];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one CPU bus cycle from a negedge and wait until the next negedge.
  task automatic applyStimulus(input logic csb, input logic wrb, input logic [12:0] a, input logic [7:0] d);
    cpuCsb = csb;
    cpuWrb = wrb;
    cpuA   = a;
    cpuDi  = d;
    @(negedge clk);
  endtask

  task automatic cpuWrite(input logic [12:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, a, d);
    model[a] = d;
    cpuCsb = 1'b1;
    cpuWrb = 1'b1;
  endtask

  task automatic pulseMount(input logic [31:0] size);
    imgSize    = size;
    imgMounted = 1'b1;
    @(negedge clk);
    imgMounted = 1'b0;
  endtask

  task automatic pulseSave();
    saveReq = 1'b1;
    @(negedge clk);
    saveReq = 1'b0;
  endtask

  task automatic waitDone(input string name, input int limit);
    int c;
    for (c = 0; c < limit; c++) begin
      @(negedge clk);
      if (busy === 1'b0 && hold === 1'b0 && expReq.size() == 0 && !hostXfer)
        break;
    end
    checkOutput({name, " completes"}, 32'(c < limit), 32'd1);
  endtask

  task automatic pushBlocks(input logic dir, input int count);
    for (int b = 0; b < count; b++)
      expReq.push_back('{dir: dir, lba: 4'(b)});
  endtask

  task automatic loadPatternIntoModel();
    for (int i = 0; i < RAM_BYTES; i++)
      model[i] = 8'(i) ^ 8'(i >> 9);
  endtask

  task automatic pushModelAsSaveData();
    for (int i = 0; i < RAM_BYTES; i++)
      expData.push_back(model[i]);
  endtask

  // Host block device and scoreboard monitor: every request the DUT raises is
  // matched against the expected queue, and save bytes against the data queue.
  initial begin : hostProc
    req_t       got;
    req_t       exp;
    int         mism;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (sdRd === 1'b1 || sdWr === 1'b1) begin
        got = '{dir: sdWr, lba: sdLba};
        reqSeen++;
        if (expReq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected request: got dir=%0d lba=%0d, required none", got.dir, got.lba);
        end else begin
          exp = expReq.pop_front();
          checkOutput("request dir/lba", 32'(got), 32'(exp));
        end
        sdAck = 1'b1;
        @(negedge clk);
        hostXfer = 1'b1;
        if (!got.dir) begin
          for (int a = 0; a < BLK_BYTES; a++) begin
            sdBuffAddr = 9'(a);
            sdBuffDout = 8'(a) ^ 8'(got.lba);
            sdBuffWr   = 1'b1;
            @(negedge clk);
          end
          sdBuffWr = 1'b0;
        end else begin
          mism = 0;
          for (int a = 0; a <= BLK_BYTES; a++) begin
            if (a > 0) begin
              want = (expData.size() != 0) ? expData.pop_front() : 8'hxx;
              if (sdBuffDin !== want)
                mism++;
            end
            if (a < BLK_BYTES) begin
              sdBuffAddr = 9'(a);
              @(negedge clk);
            end
          end
          checkOutput($sformatf("save data block %0d mismatches", got.lba), 32'(mism), 32'd0);
        end
        hostXfer = 1'b0;
        sdAck    = 1'b0;
      end
    end
  end

  initial begin : mainProc
    int  mism;
    int  seenBefore;
    int  gaps;
    bit  started;
    bit  done;
    bit  didSave;
    bit  didMnt1;
    bit  didMnt2;
    bit  found;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset hold", 32'(hold), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset dirty", 32'(dirty), 32'd0);
    checkOutput("reset sd_rd", 32'(sdRd), 32'd0);
    checkOutput("reset sd_wr", 32'(sdWr), 32'd0);
    checkOutput("reset sd_lba", 32'(sdLba), 32'd0);
    resb = 1'b1;
    @(negedge clk);

    $display("[TB] cpu write and readback");
    cpuWrite(13'h0123, 8'h5A);
    checkOutput("dirty after cpu write", 32'(dirty), 32'd1);
    checkOutput("ram at 0x0123", 32'(ramMem[13'h0123]), 32'h5A);
    applyStimulus(1'b0, 1'b1, 13'h0123, 8'h00);
    checkOutput("cpu readback", 32'(cpuDo), 32'h5A);
    applyStimulus(1'b1, 1'b1, 13'h0000, 8'h00);

    $display("[TB] save request before any mount");
    seenBefore = reqSeen;
    pulseSave();
    repeat (10) @(negedge clk);
    checkOutput("unmounted save ignored busy", 32'(busy), 32'd0);
    checkOutput("unmounted save ignored requests", 32'(reqSeen - seenBefore), 32'd0);

    $display("[TB] image load");
    pushBlocks(1'b0, 16);
    loadPatternIntoModel();
    pulseMount(32'd8192);
    waitDone("load", 20000);
    checkOutput("dirty after load", 32'(dirty), 32'd0);
    checkOutput("hold after load", 32'(hold), 32'd0);
    mism = 0;
    for (int i = 0; i < RAM_BYTES; i++)
      if (ramMem[i] !== model[i])
        mism++;
    checkOutput("loaded image mismatches", 32'(mism), 32'd0);
    checkOutput("ram at 0x1FFF", 32'(ramMem[13'h1FFF]), 32'hF0);

    $display("[TB] zero-size mount and clean save");
    pulseMount(32'd0);
    seenBefore = reqSeen;
    pulseSave();
    repeat (20) @(negedge clk);
    checkOutput("clean save ignored busy", 32'(busy), 32'd0);
    checkOutput("clean save ignored requests", 32'(reqSeen - seenBefore), 32'd0);
    cpuWrite(13'h0456, 8'hA5);
    checkOutput("dirty before save", 32'(dirty), 32'd1);

    $display("[TB] save held off by cpu access");
    pushBlocks(1'b1, 16);
    pushModelAsSaveData();
    cpuCsb  = 1'b0;
    cpuWrb  = 1'b1;
    cpuA    = 13'h0123;
    saveReq = 1'b1;
    @(negedge clk);
    saveReq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold low while cpu selected %0d", k), 32'(hold), 32'd0);
      @(negedge clk);
    end
    checkOutput("busy while waiting for cpu", 32'(busy), 32'd1);
    cpuCsb = 1'b1;
    @(negedge clk);
    checkOutput("hold after cpu release", 32'(hold), 32'd1);
    waitDone("save", 20000);
    checkOutput("dirty after save", 32'(dirty), 32'd0);
    checkOutput("save data consumed", 32'(expData.size()), 32'd0);

    $display("[TB] save queued behind load");
    cpuWrite(13'h0999, 8'h22);
    pushBlocks(1'b0, 16);
    pushBlocks(1'b1, 16);
    loadPatternIntoModel();
    pushModelAsSaveData();
    pulseMount(32'd8192);
    started = 0; done = 0; gaps = 0;
    didSave = 0; didMnt1 = 0; didMnt2 = 0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      imgMounted = 1'b0;
      saveReq    = 1'b0;
      if (busy === 1'b1)
        started = 1;
      else if (started && expReq.size() != 0)
        gaps++;
      if (started && busy === 1'b0 && expReq.size() == 0 && !hostXfer) begin
        done = 1;
        break;
      end
      if (!didSave && busy === 1'b1 && sdLba == 4'd7) begin
        saveReq    = 1'b1;
        imgSize    = 32'd8192;
        imgMounted = 1'b1;
        didSave    = 1;
        didMnt1    = 1;
      end else if (didSave && !didMnt2 && sdWr === 1'b1 && sdLba == 4'd5) begin
        imgSize    = 32'd8192;
        imgMounted = 1'b1;
        didMnt2    = 1;
      end
    end
    imgMounted = 1'b0;
    saveReq    = 1'b0;
    checkOutput("load then save completes", 32'(done), 32'd1);
    checkOutput("save requested during load", 32'(didSave && didMnt1), 32'd1);
    checkOutput("mount pulsed during save", 32'(didMnt2), 32'd1);
    checkOutput("busy gaps between load and save", 32'(gaps), 32'd0);
    checkOutput("dirty after load+save", 32'(dirty), 32'd0);
    checkOutput("save data consumed after load+save", 32'(expData.size()), 32'd0);

    $display("[TB] reset during block 3");
    cpuWrite(13'h0042, 8'h77);
    pushBlocks(1'b0, 4);
    pulseMount(32'd8192);
    found = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (hostXfer && sdLba == 4'd3) begin
        found = 1;
        break;
      end
    end
    checkOutput("reached block 3 transfer", 32'(found), 32'd1);
    repeat (20) @(negedge clk);
    resb = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort sd_rd", 32'(sdRd), 32'd0);
    checkOutput("abort sd_wr", 32'(sdWr), 32'd0);
    checkOutput("abort hold", 32'(hold), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort dirty", 32'(dirty), 32'd0);
    checkOutput("abort sd_lba", 32'(sdLba), 32'd0);
    cpuA   = 13'h0321;
    cpuCsb = 1'b0;
    cpuWrb = 1'b1;
    #1;
    checkOutput("cpu owns ram address", 32'(ramA), 32'h0321);
    checkOutput("cpu owns ram select", 32'(ramCsb), 32'd0);
    @(negedge clk);
    resb   = 1'b1;
    cpuCsb = 1'b1;
    checkOutput("aborted load requests consumed", 32'(expReq.size()), 32'd0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
